// File: rtl/pipo_write_arbiter.sv
// pipo_write_arbiter: request/grant/ack arbiter in front of one shared PIPO holding register.
// Build option PIPO_ARB_FIXED_PRI_EN: lowest asserted index always wins (no round-robin pointer).
module pipo_write_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   pi,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         ack,
  output logic [WIDTH-1:0]        po,
  output logic                    po_valid,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t                     state, state_nxt;
  logic [IW-1:0]              cur, win;
  logic [NREQ-1:0][WIDTH-1:0] slice;
  logic [NREQ-1:0]            gnt_d, ack_d;
  logic                       load;

  assign slice = pi;

`ifdef PIPO_ARB_FIXED_PRI_EN
  always_comb begin
    win = '0;
    for (int k = NREQ-1; k >= 0; k--)
      if (req[k]) win = IW'(k);
  end
`else
  logic [IW-1:0] ptr;

  // First asserted request at or above ptr, wrapping at NREQ.
  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = GRANT;
      GRANT:   state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs; every output leaves the block from a flop.
  always_comb begin
    gnt_d = '0;
    ack_d = '0;
    load  = 1'b0;
    case (state)
      IDLE:  if (|req) gnt_d[win] = 1'b1;
      GRANT: if (req[cur]) begin
        ack_d[cur] = 1'b1;
        load       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt      <= '0;
      ack      <= '0;
      po       <= '0;
      po_valid <= 1'b0;
      owner    <= '0;
      busy     <= 1'b0;
      cur      <= '0;
`ifndef PIPO_ARB_FIXED_PRI_EN
      ptr      <= '0;
`endif
    end else begin
      gnt  <= gnt_d;
      ack  <= ack_d;
      busy <= (state_nxt != IDLE);
      if (state == IDLE) cur <= win;
      if (load) begin
        po       <= slice[cur];
        owner    <= cur;
        po_valid <= 1'b1;
`ifndef PIPO_ARB_FIXED_PRI_EN
        ptr      <= (cur == IW'(NREQ-1)) ? '0 : cur + 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_pipo_write_arbiter.sv
// Directed bench for pipo_write_arbiter: transaction-level model checked every cycle, plus literal checks.
module tb_pipo_write_arbiter;
  logic        clk, rst;
  logic [3:0]  req;
  logic [15:0] pi;
  logic [3:0]  gnt, ack, po;
  logic        po_valid, busy;
  logic [1:0]  owner;

  int n_chk = 0, n_fail = 0;

`ifdef PIPO_ARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  pipo_write_arbiter #(.WIDTH(4), .NREQ(4)) dut (
    .clk(clk), .rst(rst), .req(req), .pi(pi), .gnt(gnt), .ack(ack),
    .po(po), .po_valid(po_valid), .owner(owner), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a write is a 3-cycle transaction (grant, load-or-abort, dead cycle).
  int         m_phase, m_ptr, m_cur;
  logic [3:0] m_gnt, m_ack, m_po;
  logic       m_valid, m_busy;
  logic [1:0] m_owner;
  bit         started = 1'b0;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = FIXED ? k : (p + k) % 4;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      started = 1'b1;
      m_phase = 0; m_ptr = 0; m_cur = 0;
      m_gnt = '0; m_ack = '0; m_po = '0; m_valid = 1'b0; m_owner = '0; m_busy = 1'b0;
    end else begin
      m_gnt = '0;
      m_ack = '0;
      if (m_phase == 0) begin
        if (req != 0) begin
          m_cur   = pick(req, m_ptr);
          m_gnt   = 4'(1 << m_cur);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (req[m_cur]) begin
          m_po    = pi[m_cur*4 +: 4];
          m_ack   = 4'(1 << m_cur);
          m_owner = 2'(m_cur);
          m_valid = 1'b1;
          m_ptr   = (m_cur + 1) % 4;
        end
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
      m_busy = (m_phase != 0);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cyc_gnt", 32'(gnt), 32'(m_gnt));
      chk("cyc_ack", 32'(ack), 32'(m_ack));
      chk("cyc_po", 32'(po), 32'(m_po));
      chk("cyc_po_valid", 32'(po_valid), 32'(m_valid));
      chk("cyc_owner", 32'(owner), 32'(m_owner));
      chk("cyc_busy", 32'(busy), 32'(m_busy));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction

  initial begin
    int order [5];
    int n;
    rst = 1'b1; req = 4'b1111; pi = 16'h4321;
    // Reset with all requests high
    cyc();
    chk("rst_gnt", 32'(gnt), 0);
    cyc();
    chk("rst_gnt2", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_po", 32'(po), 0);
    chk("rst_valid", 32'(po_valid), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    cyc();
    chk("rst_first_gnt", 32'(gnt), 32'h1);

    // Round-robin with req held at 1111
    for (int j = 0; j < 5; j++) begin
      n = 0;
      while (gnt == 0 && n < 20) begin cyc(); n++; end
      if (gnt == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rr_timeout: got no grant expected grant %0d", j);
        order[j] = -1;
      end else begin
        order[j] = idx_of(gnt);
      end
      cyc();
      if (j == 0) chk("rr_po0", 32'(po), 32'h1);
    end
    for (int j = 0; j < 5; j++)
      chk("rr_order", 32'(order[j]), FIXED ? 0 : 32'(j % 4));

    rst = 1'b1; req = 4'b0000;
    cyc(2);
    rst = 1'b0;

    // Single write by requester 2
    pi = 16'h0A00; req = 4'b0100;
    cyc();
    chk("sw_gnt", 32'(gnt), 32'h4);
    chk("sw_busy", 32'(busy), 1);
    cyc();
    chk("sw_ack", 32'(ack), 32'h4);
    chk("sw_po", 32'(po), 32'hA);
    chk("sw_owner", 32'(owner), 2);
    chk("sw_valid", 32'(po_valid), 1);
    req = 4'b0000;
    cyc();
    chk("sw_ack_clr", 32'(ack), 0);
    cyc();
    chk("sw_busy_low", 32'(busy), 0);

    // Wrap-around from ptr = 3
    pi = 16'h9007; req = 4'b1001;
    cyc();
    chk("wr_gnt1", 32'(gnt), FIXED ? 32'h1 : 32'h8);
    cyc(3);
    chk("wr_gnt2", 32'(gnt), 32'h1);
    cyc();
    chk("wr_ack2", 32'(ack), 32'h1);
    chk("wr_po", 32'(po), 32'h7);
    chk("wr_owner", 32'(owner), 0);
    req = 4'b0000;
    cyc(2);

    // Abort: requester 1 drops during GRANT
    pi = 16'h00F0; req = 4'b0010;
    cyc();
    chk("ab_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    cyc();
    chk("ab_ack", 32'(ack), 0);
    chk("ab_po", 32'(po), 32'h7);
    chk("ab_owner", 32'(owner), 0);
    cyc();
    req = 4'b0011;
    cyc();
    chk("ab_next_gnt", 32'(gnt), FIXED ? 32'h1 : 32'h2);
    cyc();
    req = 4'b0000;
    cyc(2);

    // Reset during GRANT discards the load
    pi = 16'h0005; req = 4'b0001;
    cyc();
    chk("mr_gnt", 32'(gnt), 32'h1);
    rst = 1'b1;
    cyc();
    chk("mr_po", 32'(po), 0);
    chk("mr_ack", 32'(ack), 0);
    chk("mr_valid", 32'(po_valid), 0);
    chk("mr_busy", 32'(busy), 0);
    rst = 1'b0; req = 4'b0000;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
